adder_sum_accum: RTL and testbench
==================================

# adder_sum_accum

Sequential accumulator directly downstream of the 4-bit ripple adder. Each accepted beat takes the adder's 4-bit sum and carry-out as one 5-bit value (0..31) and adds it into a wide running total. After a fixed number of beats it presents the total and a sticky overflow flag on a valid/ready output port. It converts per-cycle 4-bit adder results into a single multi-beat sum for the next stage.

## Interface
- ACC_W, 12, accumulator width in bits; must be ≥ 5
- BEATS, 8, number of input beats per run; must be ≥ 1
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a run; honoured only in IDLE
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat
- in_sum  in  4  sum bits from the 4-bit adder
- in_carry  in  1  carry-out from the 4-bit adder
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_acc  out  ACC_W  accumulated total
- out_ovf  out  1  sticky: total exceeded 2^ACC_W−1 during the run
- busy  out  1  high in ACCUM or DONE

## Operation
- The FSM has three states: IDLE, ACCUM and DONE.
- **IDLE**
  - in_ready=0, out_valid=0.
  - On start=1, clear acc, beat counter and ovf, then go to ACCUM.
- **ACCUM**
  - in_ready=1 combinationally.
  - A beat is accepted when in_valid && in_ready.
  - On each beat: acc ← (acc + {in_carry,in_sum}) mod 2^ACC_W, with {in_carry,in_sum} zero-extended.
  - Do the add ACC_W+1 bits wide; if bit ACC_W is set, set ovf. Once set, ovf stays set for the rest of the run.
  - Counter increments per beat. A beat accepted while counter == BEATS−1 moves the FSM to DONE.
- **DONE**
  - out_valid=1; out_acc and out_ovf are held stable.
  - On out_valid && out_ready, go to IDLE. acc and ovf keep their values until the next start.
- start outside IDLE is ignored; it has no effect on acc, counter or state.
- in_valid outside ACCUM is ignored (in_ready=0).
- out_acc always shows the acc register; downstream may use it only while out_valid=1.
- Counter width is $clog2(BEATS+1).

## Timing
- Reset (async assert, sync release), all of these 0: state=IDLE, acc, counter, ovf, in_ready, out_valid, out_acc, out_ovf, busy.
- start sampled at cycle t gives in_ready=1 from cycle t+1.
- Throughput is up to one beat per cycle; gaps in in_valid only stall the run.
- Last beat accepted at cycle t gives out_valid=1 at t+1, carrying the final acc including that beat.
- out_ready held low leaves out_valid, out_acc and out_ovf unchanged indefinitely.
- Handshake at cycle t gives IDLE at t+1. A start at t+1 is accepted, so the minimum gap between runs is one cycle.
- rst_n asserted mid-run (ACCUM or DONE) aborts immediately to reset values; no partial result is emitted.
- BEATS=1: the first accepted beat goes directly to DONE.

## Structure
- Shared package adder_pkg holds:
  - the state typedef (IDLE=2'b00, ACCUM=2'b01, DONE=2'b10);
  - localparam SUM_W=5 (carry plus 4 sum bits).
- Flat implementation with no sub-module. The datapath is one ACC_W+1-bit adder plus registers; the FSM is in the same module.

## Test plan
- Reset → all outputs 0. start, then 8 beats of {1,4'hF} with ACC_W=12, BEATS=8 → out_valid one cycle after beat 8, out_acc=248, out_ovf=0.
- ACC_W=8, BEATS=9, 9 beats of 31 → out_acc=23 (279 mod 256), out_ovf=1. Next run of 9 beats of 0 → out_acc=0, out_ovf=0.
- in_valid toggled 1,0,0,1,… with beats 1..8 → total 36; out_ready held low 5 cycles → out_acc=36 stable throughout; IDLE the cycle after handshake.
- start pulsed during ACCUM and during DONE → no restart, result unchanged. Back-to-back runs with start the cycle after handshake → both results correct.
- rst_n dropped after 3 of 8 beats → all outputs 0 asynchronously, in_ready=0. New run of 8 beats of 5 → out_acc=40.
- BEATS=1, one beat {0,4'h7} → out_valid next cycle, out_acc=7.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the 4-bit adder result accumulator: FSM state
// encoding, the beat width and a helper that packs one adder result.
package adder_pkg;

  // Accumulator control states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  // One beat is the adder carry-out plus its 4 sum bits.
  localparam int SUM_W = 5;

  // Packs an adder result into a single unsigned beat value (0..31).
  function automatic logic [SUM_W-1:0] pack_beat(input logic carry, input logic [3:0] sum);
    return {carry, sum};
  endfunction

endpackage

// File: rtl/adder_sum_accum.sv
// Multi-beat accumulator for the 4-bit ripple adder. Each accepted beat adds
// {carry,sum} into a running total; after BEATS beats the total and a sticky
// overflow flag are offered on a valid/ready result port.
module adder_sum_accum
  import adder_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int BEATS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t             state_r;
  state_t             state_next_s;
  logic [ACC_W-1:0]   acc_r;
  logic               ovf_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               beat_s;
  logic               start_s;
  logic               last_beat_s;
  logic [ACC_W:0]     sum_wide_s;

  // A beat is only taken while ACCUM is advertising in_ready.
  assign beat_s      = (state_r == ACCUM) && in_valid;
  assign start_s     = (state_r == IDLE) && start;
  assign last_beat_s = beat_s && (cnt_r == LAST_BEAT);

  // One extra bit on the adder exposes the wrap past 2^ACC_W-1.
  assign sum_wide_s = {1'b0, acc_r}
                    + {{(ACC_W + 1 - SUM_W){1'b0}}, pack_beat(in_carry, in_sum)};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: start only counts in IDLE, result leaves on handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (last_beat_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath: clear on an honoured start, accumulate on each beat, else hold
  // so the result stays readable after the handshake until the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (start_s) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (beat_s) begin
      acc_r <= sum_wide_s[ACC_W-1:0];
      ovf_r <= ovf_r | sum_wide_s[ACC_W];
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      acc_r <= acc_r;
      ovf_r <= ovf_r;
      cnt_r <= cnt_r;
    end
  end

  // Port decode straight from registered state and datapath.
  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_acc   = acc_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_adder_sum_accum.sv
// Scoreboard bench for adder_sum_accum: three instances cover the default
// configuration, a narrow overflowing accumulator and the single-beat case.
module tb_adder_sum_accum;

  typedef struct packed {
    logic        ovf;
    logic [11:0] acc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic start;
  logic in_valid;
  logic [3:0] in_sum;
  logic in_carry;
  logic out_ready;
  int   sel;

  logic a_start, b_start, c_start;
  logic a_in_ready, b_in_ready, c_in_ready;
  logic a_out_valid, b_out_valid, c_out_valid;
  logic [11:0] a_out_acc;
  logic [7:0]  b_out_acc;
  logic [11:0] c_out_acc;
  logic a_out_ovf, b_out_ovf, c_out_ovf;
  logic a_busy, b_busy, c_busy;

  logic sel_in_ready, sel_out_valid, sel_busy;
  logic [11:0] sel_acc;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int errors = 0;
  int checks = 0;

  assign a_start = start && (sel == 0);
  assign b_start = start && (sel == 1);
  assign c_start = start && (sel == 2);

  adder_sum_accum #(.ACC_W(12), .BEATS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_acc(a_out_acc), .out_ovf(a_out_ovf), .busy(a_busy));

  adder_sum_accum #(.ACC_W(8), .BEATS(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_acc(b_out_acc), .out_ovf(b_out_ovf), .busy(b_busy));

  adder_sum_accum #(.ACC_W(12), .BEATS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_acc(c_out_acc), .out_ovf(c_out_ovf), .busy(c_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the instance under test to common observation signals.
  always_comb begin
    sel_in_ready  = a_in_ready;
    sel_out_valid = a_out_valid;
    sel_busy      = a_busy;
    sel_acc       = a_out_acc;
    case (sel)
      1: begin
        sel_in_ready  = b_in_ready;
        sel_out_valid = b_out_valid;
        sel_busy      = b_busy;
        sel_acc       = {4'b0000, b_out_acc};
      end
      2: begin
        sel_in_ready  = c_in_ready;
        sel_out_valid = c_out_valid;
        sel_busy      = c_busy;
        sel_acc       = c_out_acc;
      end
      default: begin
        sel_in_ready  = a_in_ready;
        sel_out_valid = a_out_valid;
        sel_busy      = a_busy;
        sel_acc       = a_out_acc;
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for instance A: pop and compare on every result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid && out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_a: unexpected result acc=%0d", a_out_acc);
      end else begin
        e = qa.pop_front();
        chk("result_acc_a", 32'(a_out_acc), 32'(e.acc));
        chk("result_ovf_a", 32'(a_out_ovf), 32'(e.ovf));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (b_out_valid && out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_b: unexpected result acc=%0d", b_out_acc);
      end else begin
        e = qb.pop_front();
        chk("result_acc_b", 32'(b_out_acc), 32'(e.acc));
        chk("result_ovf_b", 32'(b_out_ovf), 32'(e.ovf));
      end
    end
  end

  // Monitor for instance C.
  always @(negedge clk) begin
    exp_t e;
    if (c_out_valid && out_ready) begin
      if (qc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_c: unexpected result acc=%0d", c_out_acc);
      end else begin
        e = qc.pop_front();
        chk("result_acc_c", 32'(c_out_acc), 32'(e.acc));
        chk("result_ovf_c", 32'(c_out_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic start_run(input bit do_push, input logic ovf, input logic [11:0] acc);
    exp_t e;
    e.ovf = ovf;
    e.acc = acc;
    if (do_push) begin
      case (sel)
        1:       qb.push_back(e);
        2:       qc.push_back(e);
        default: qa.push_back(e);
      endcase
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("in_ready_after_start", 32'(sel_in_ready), 32'd1);
  endtask

  task automatic beat(input logic c, input logic [3:0] s, input int gap);
    in_valid = 1'b1;
    in_carry = c;
    in_sum   = s;
    step();
    in_valid = 1'b0;
    in_carry = 1'b0;
    in_sum   = 4'h0;
    repeat (gap) step();
  endtask

  // Expect the result right after the last beat, optionally stall it for
  // `hold` cycles (pulsing start on the first), then handshake.
  task automatic finish_run(input int hold, input logic [11:0] exp_acc, input bit pulse);
    int n;
    n = 0;
    while (!sel_out_valid && n < 20) begin
      step();
      n++;
    end
    chk("valid_latency", 32'(n), 32'd0);
    chk("out_valid", 32'(sel_out_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      start = pulse && (i == 0);
      step();
      start = 1'b0;
      chk("stall_valid", 32'(sel_out_valid), 32'd1);
      chk("stall_acc", 32'(sel_acc), 32'(exp_acc));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_after_hs_valid", 32'(sel_out_valid), 32'd0);
    chk("idle_after_hs_busy", 32'(sel_busy), 32'd0);
    chk("idle_after_hs_acc", 32'(sel_acc), 32'(exp_acc));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 4'h0;
    in_carry  = 1'b0;
    out_ready = 1'b0;
    sel       = 0;
    #12;
    chk("reset_a", {a_in_ready, a_out_valid, a_out_ovf, a_busy, 16'(a_out_acc)}, 32'd0);
    chk("reset_b", {b_in_ready, b_out_valid, b_out_ovf, b_busy, 8'(b_out_acc)}, 32'd0);
    chk("reset_c", {c_in_ready, c_out_valid, c_out_ovf, c_busy, 16'(c_out_acc)}, 32'd0);
    rst_n = 1'b1;
    step();

    // 8 beats of 31 -> 248, no overflow.
    sel = 0;
    start_run(1'b1, 1'b0, 12'd248);
    for (int i = 0; i < 8; i++) beat(1'b1, 4'hF, 0);
    finish_run(0, 12'd248, 1'b0);

    // Gapped beats 1..8 -> 36, start during ACCUM and DONE, stalled 5 cycles.
    step();
    start_run(1'b1, 1'b0, 12'd36);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) start = 1'b1;
      beat(1'b0, 4'(i), (i == 8) ? 0 : 2);
      start = 1'b0;
    end
    finish_run(5, 12'd36, 1'b1);

    // Back-to-back runs: start the cycle right after the handshake.
    start_run(1'b1, 1'b0, 12'd128);
    for (int i = 0; i < 8; i++) beat(1'b1, 4'h0, 0);
    finish_run(0, 12'd128, 1'b0);
    start_run(1'b1, 1'b0, 12'd24);
    for (int i = 0; i < 8; i++) beat(1'b0, 4'h3, 0);
    finish_run(0, 12'd24, 1'b0);

    // in_valid in IDLE must not touch the held result.
    in_valid = 1'b1;
    in_sum   = 4'h9;
    step();
    step();
    in_valid = 1'b0;
    in_sum   = 4'h0;
    chk("idle_ignore_acc", 32'(a_out_acc), 32'd24);
    chk("idle_ignore_busy", 32'(a_busy), 32'd0);

    // Reset after 3 of 8 beats aborts with no result.
    start_run(1'b0, 1'b0, 12'd0);
    for (int i = 0; i < 3; i++) beat(1'b0, 4'h5, 0);
    chk("partial_acc", 32'(a_out_acc), 32'd15);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {a_in_ready, a_out_valid, a_out_ovf, a_busy, 16'(a_out_acc)}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    start_run(1'b1, 1'b0, 12'd40);
    for (int i = 0; i < 8; i++) beat(1'b0, 4'h5, 0);
    finish_run(0, 12'd40, 1'b0);

    // ACC_W=8, BEATS=9: 9 x 31 = 279 -> 23 with overflow, then a clean zero run.
    sel = 1;
    step();
    start_run(1'b1, 1'b1, 12'd23);
    for (int i = 0; i < 9; i++) beat(1'b1, 4'hF, 0);
    chk("ovf_b_flag", 32'(b_out_ovf), 32'd1);
    finish_run(0, 12'd23, 1'b0);
    start_run(1'b1, 1'b0, 12'd0);
    for (int i = 0; i < 9; i++) beat(1'b0, 4'h0, 0);
    chk("ovf_b_cleared", 32'(b_out_ovf), 32'd0);
    finish_run(0, 12'd0, 1'b0);

    // BEATS=1: one beat of 7 goes straight to DONE.
    sel = 2;
    step();
    start_run(1'b1, 1'b0, 12'd7);
    beat(1'b0, 4'h7, 0);
    finish_run(0, 12'd7, 1'b0);

    step();
    chk("queue_a_empty", 32'(qa.size()), 32'd0);
    chk("queue_b_empty", 32'(qb.size()), 32'd0);
    chk("queue_c_empty", 32'(qc.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
